// File: rtl/bus_arb_pkg.sv
// Shared constants for the 4-master round-robin bus arbiter: FSM encodings, master count, idle grant.
// Latency and backpressure: none here, constants and one helper only.
package bus_arb_pkg;

  localparam int         MASTER_NUM = 4;
  localparam int         HOLD_W     = 8;
  localparam logic [3:0] GRNT_IDLE  = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef logic [1:0] master_idx_t;

  // Active-low grant vector with only master idx low.
  function automatic logic [3:0] grant_for(input master_idx_t idx);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first active request after last, wrapping, last itself lowest.
// Latency 0 (pure combinational); no backpressure.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [MASTER_NUM-1:0] req,
  input  master_idx_t           last,
  output master_idx_t           winner,
  output logic                  found
);

  always_comb begin
    winner = last;
    found  = 1'b0;
    // 2-bit add wraps mod 4; k==4 lands back on last, giving it lowest priority.
    for (int k = 1; k <= MASTER_NUM; k++) begin
      if (!found && req[last + 2'(k)]) begin
        winner = last + 2'(k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter, 4 active-low masters, one dead cycle between owners, timeout preemption.
// Latency: request to grant 1 cycle; backpressure: timeout preemption waits for bus_rdy_ low.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int MASTER_NUM = bus_arb_pkg::MASTER_NUM
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_NUM-1:0] m_req_,
  input  logic                  bus_rdy_,
  output logic [MASTER_NUM-1:0] m_grnt_,
  output logic [1:0]            owner,
  output logic                  owner_vld,
  output logic                  preempt
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]            state_q, state_d;
  logic [MASTER_NUM-1:0] grnt_q, grnt_d;
  master_idx_t           owner_q, owner_d;
  master_idx_t           last_owner_q, last_owner_d;
  logic                  owner_vld_q, owner_vld_d;
  logic                  preempt_q, preempt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;

  logic [MASTER_NUM-1:0] req;
  master_idx_t           pick_idx;
  logic                  pick_found;
  logic                  owner_req;
  logic                  others_req;
  logic                  hold_at_max;

  assign req         = ~m_req_;
  assign owner_req   = req[owner_q];
  assign others_req  = |(req & grant_for(owner_q));
  assign hold_at_max = (hold_cnt_q == HOLD_MAX);

  rr_pick u_rr_pick (
    .req    (req),
    .last   (last_owner_q),
    .winner (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    state_d      = state_q;
    grnt_d       = grnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    owner_vld_d  = owner_vld_q;
    preempt_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      // GAP arbitrates exactly like IDLE; last_owner already names the departing master.
      ST_IDLE, ST_GAP: begin
        if (pick_found) begin
          state_d     = ST_OWN;
          grnt_d      = grant_for(pick_idx);
          owner_d     = pick_idx;
          owner_vld_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          state_d     = ST_IDLE;
          grnt_d      = GRNT_IDLE;
          owner_vld_d = 1'b0;
        end
      end
      ST_OWN: begin
        if (!owner_req || (hold_at_max && others_req && !bus_rdy_)) begin
          state_d      = ST_GAP;
          grnt_d       = GRNT_IDLE;
          owner_vld_d  = 1'b0;
          last_owner_d = owner_q;
          preempt_d    = owner_req;
        end else if (!hold_at_max) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grnt_d      = GRNT_IDLE;
        owner_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grnt_q       <= GRNT_IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      owner_vld_q  <= 1'b0;
      preempt_q    <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grnt_q       <= grnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      owner_vld_q  <= owner_vld_d;
      preempt_q    <= preempt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign m_grnt_   = grnt_q;
  assign owner     = owner_q;
  assign owner_vld = owner_vld_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter with MAX_HOLD=4: directed vector table, corner sequences, random vs model.
module tb_bus_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] m_req_;
  logic       bus_rdy_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;
  logic       owner_vld;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  bus_rr_arbiter #(.MAX_HOLD(MAXH), .MASTER_NUM(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req_    (m_req_),
    .bus_rdy_  (bus_rdy_),
    .m_grnt_   (m_grnt_),
    .owner     (owner),
    .owner_vld (owner_vld),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req_n;
    logic       rdy_n;
    logic [3:0] g;
    logic       v;
    logic       p;
    logic [1:0] o;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic rst, logic [3:0] req_n, logic rdy_n,
                              logic [3:0] g, logic v, logic p, logic [1:0] o);
    vec_t t;
    t.rst = rst; t.req_n = req_n; t.rdy_n = rdy_n;
    t.g = g; t.v = v; t.p = p; t.o = o;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual{grnt,vld,pre,own}=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic expect_out(string nm, logic [3:0] g, logic v, logic p, logic [1:0] o);
    logic [7:0] act;
    logic [7:0] exp;
    act = {m_grnt_, owner_vld, preempt, owner_vld ? owner : 2'b00};
    exp = {g, v, p, v ? o : 2'b00};
    chk(nm, act, exp);
  endtask

  // Reference model: who holds the bus, for how many cycles, and who held it last.
  int         m_own;
  int         m_held;
  int         m_last;
  bit         m_pre;

  function automatic int rr_next(logic [3:0] req_n, int from);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (from + k) % 4;
      if (!req_n[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(logic rst, logic [3:0] req_n, logic rdy_n);
    int w;
    int others;
    if (rst) begin
      m_own = -1; m_held = 0; m_last = 3; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_own < 0) begin
      w = rr_next(req_n, m_last);
      if (w >= 0) begin
        m_own  = w;
        m_held = 0;
      end
    end else begin
      others = 0;
      for (int j = 0; j < 4; j++) if (j != m_own && !req_n[j]) others++;
      if (req_n[m_own]) begin
        m_last = m_own; m_own = -1;
      end else if (m_held >= MAXH && others > 0 && !rdy_n) begin
        m_last = m_own; m_own = -1; m_pre = 1;
      end else if (m_held < MAXH) begin
        m_held++;
      end
    end
  endtask

  task automatic model_check(string nm);
    logic [3:0] one;
    logic [3:0] g;
    one = 4'b0001;
    g = (m_own >= 0) ? ~(one << m_own) : 4'b1111;
    expect_out(nm, g, m_own >= 0, m_pre, 2'(m_own));
  endtask

  initial begin
    reset = 1'b1; m_req_ = 4'b1111; bus_rdy_ = 1'b1;
    #1;
    expect_out("reset_state", 4'b1111, 1'b0, 1'b0, 2'd0);
    chk("reset_owner", {6'd0, owner}, 8'd0);
    tick(); tick();

    vecs[0]  = mk(0, 4'b1110, 1, 4'b1110, 1, 0, 2'd0);
    vecs[1]  = mk(0, 4'b1111, 1, 4'b1111, 0, 0, 2'd0);
    vecs[2]  = mk(0, 4'b1111, 1, 4'b1111, 0, 0, 2'd0);
    vecs[3]  = mk(1, 4'b1111, 1, 4'b1111, 0, 0, 2'd0);
    vecs[4]  = mk(0, 4'b0000, 1, 4'b1110, 1, 0, 2'd0);
    vecs[5]  = mk(0, 4'b0000, 1, 4'b1110, 1, 0, 2'd0);
    vecs[6]  = mk(0, 4'b0000, 1, 4'b1110, 1, 0, 2'd0);
    vecs[7]  = mk(0, 4'b0001, 1, 4'b1111, 0, 0, 2'd0);
    vecs[8]  = mk(0, 4'b0001, 1, 4'b1101, 1, 0, 2'd1);
    vecs[9]  = mk(0, 4'b0001, 1, 4'b1101, 1, 0, 2'd1);
    vecs[10] = mk(0, 4'b0001, 1, 4'b1101, 1, 0, 2'd1);
    vecs[11] = mk(0, 4'b0011, 1, 4'b1111, 0, 0, 2'd0);
    vecs[12] = mk(0, 4'b0011, 1, 4'b1011, 1, 0, 2'd2);
    vecs[13] = mk(0, 4'b0011, 1, 4'b1011, 1, 0, 2'd2);
    vecs[14] = mk(0, 4'b0011, 1, 4'b1011, 1, 0, 2'd2);
    vecs[15] = mk(0, 4'b0111, 1, 4'b1111, 0, 0, 2'd0);
    vecs[16] = mk(0, 4'b0111, 1, 4'b0111, 1, 0, 2'd3);
    vecs[17] = mk(0, 4'b0111, 1, 4'b0111, 1, 0, 2'd3);
    vecs[18] = mk(0, 4'b0111, 1, 4'b0111, 1, 0, 2'd3);
    vecs[19] = mk(0, 4'b1111, 1, 4'b1111, 0, 0, 2'd0);
    vecs[20] = mk(0, 4'b1111, 1, 4'b1111, 0, 0, 2'd0);
    vecs[21] = mk(0, 4'b1101, 1, 4'b1101, 1, 0, 2'd1);
    vecs[22] = mk(0, 4'b1001, 1, 4'b1101, 1, 0, 2'd1);
    vecs[23] = mk(0, 4'b1001, 1, 4'b1101, 1, 0, 2'd1);
    vecs[24] = mk(0, 4'b1001, 1, 4'b1101, 1, 0, 2'd1);
    vecs[25] = mk(0, 4'b1001, 1, 4'b1101, 1, 0, 2'd1);
    vecs[26] = mk(0, 4'b1001, 0, 4'b1111, 0, 1, 2'd0);
    vecs[27] = mk(0, 4'b1001, 1, 4'b1011, 1, 0, 2'd2);
    vecs[28] = mk(0, 4'b1111, 1, 4'b1111, 0, 0, 2'd0);
    vecs[29] = mk(0, 4'b1111, 1, 4'b1111, 0, 0, 2'd0);

    for (int i = 0; i < 30; i++) begin
      reset = vecs[i].rst; m_req_ = vecs[i].req_n; bus_rdy_ = vecs[i].rdy_n;
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].v, vecs[i].p, vecs[i].o);
    end

    // Owner 1 past timeout with master 3 waiting: no preemption while bus_rdy_ stays high.
    m_req_ = 4'b1101; tick();
    expect_out("hold_m1_grant", 4'b1101, 1, 0, 2'd1);
    m_req_ = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("hold_m1_rdy_high%0d", i), 4'b1101, 1, 0, 2'd1);
    end
    bus_rdy_ = 1'b0; tick();
    expect_out("hold_m1_preempt", 4'b1111, 0, 1, 2'd0);
    bus_rdy_ = 1'b1; tick();
    expect_out("hold_m1_next_m3", 4'b0111, 1, 0, 2'd3);
    m_req_ = 4'b1111; tick(); tick();
    expect_out("hold_m1_idle", 4'b1111, 0, 0, 2'd0);

    // Sole requester 2 well past timeout keeps the grant; a newcomer preempts on first bus_rdy_ low.
    m_req_ = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      bus_rdy_ = i[0];
      tick();
      expect_out($sformatf("sole_m2_%0d", i), 4'b1011, 1, 0, 2'd2);
    end
    m_req_ = 4'b1010; bus_rdy_ = 1'b0; tick();
    expect_out("sole_m2_saturated_preempt", 4'b1111, 0, 1, 2'd0);
    bus_rdy_ = 1'b1; tick();
    expect_out("sole_m2_then_m0", 4'b1110, 1, 0, 2'd0);

    // Asynchronous reset in the middle of an owned cycle.
    m_req_ = 4'b1000; tick();
    expect_out("pre_async_own", 4'b1110, 1, 0, 2'd0);
    #2 reset = 1'b1;
    #1;
    expect_out("async_reset_no_edge", 4'b1111, 0, 0, 2'd0);
    chk("async_reset_owner", {6'd0, owner}, 8'd0);
    tick();
    reset = 1'b0; m_req_ = 4'b0000; tick();
    expect_out("post_reset_m0_first", 4'b1110, 1, 0, 2'd0);
    m_req_ = 4'b1111; tick(); tick();

    // Random traffic against the model; requests are sticky so owners hold long enough to time out.
    reset = 1'b1; model_step(1'b1, m_req_, bus_rdy_); tick();
    model_check("rand_reset");
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      r = m_req_;
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 5) == 0) r[j] = ~r[j];
      m_req_   = r;
      bus_rdy_ = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      reset    = ($urandom_range(0, 299) == 0);
      model_step(reset, m_req_, bus_rdy_);
      tick();
      model_check($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
